vga_scanout: RTL

Display-side consumer of the game pixel-read interface. Generates 640x480@60 Hz VGA timing from the 100 MHz system clock, drives `ram_addr_x`/`ram_addr_y` into a game/mini-game memory block (for example the timer game), captures the returned 16-bit `ram_data`, and drives the board VGA pins. Each 160x120 logical pixel is upscaled 4x in both directions, and a one-cycle `frame_start` pulse is produced for game logic.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_scanout_if.sv | 24 ++
 rtl/vga_timing.sv | 55 +++++
 rtl/vga_scanout.sv | 89 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and pixel-word layout for the scanout path.
package vga_pkg;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned H_FP_END   = 656;
    localparam int unsigned H_SYNC_END = 752;
    localparam int unsigned H_TOTAL    = 800;

    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned V_FP_END   = 490;
    localparam int unsigned V_SYNC_END = 492;
    localparam int unsigned V_TOTAL    = 525;

    localparam int unsigned SCALE_SHIFT = 2;

    localparam int unsigned PIX_TRANSP_BIT = 15;
    localparam int unsigned PIX_RGB_MSB    = 11;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic       transp;
        logic [2:0] rsvd;
        rgb444_t    rgb;
    } pixel_t;

    // Screen coordinate to logical (upscaled) coordinate.
    function automatic logic [7:0] scale_down(logic [9:0] c);
        return 8'(c >> SCALE_SHIFT);
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Pixel-read request/response plus board VGA pins, grouped for the scanout block.
interface vga_scanout_if;

    logic [7:0]  ram_addr_x;
    logic [7:0]  ram_addr_y;
    logic [15:0] ram_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output ram_addr_x, ram_addr_y, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
        input  ram_data
    );

    modport slave (
        input  ram_addr_x, ram_addr_y, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
        output ram_data
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel-phase divider and 800x525 raster counters with active/sync decode.
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] phase_o,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       active_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o
);

    logic [1:0] phase_q, phase_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       tick;

    assign tick = (phase_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            phase_q <= phase_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q + 2'd1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == 10'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    assign phase_o   = phase_q;
    assign h_cnt_o   = h_cnt_q;
    assign v_cnt_o   = v_cnt_q;
    assign active_o  = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    assign hsync_n_o = !((h_cnt_q >= 10'(H_FP_END)) && (h_cnt_q < 10'(H_SYNC_END)));
    assign vsync_n_o = !((v_cnt_q >= 10'(V_FP_END)) && (v_cnt_q < 10'(V_SYNC_END)));

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: 4x-upscaled address generation, latency-matched pixel capture, sync and
// frame_start outputs kept aligned with the captured colour.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master bus_io
);

    logic [1:0] phase;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hsync_n;
    logic       vsync_n;
    logic       capture;
    pixel_t     pix;
    logic       unused_rsvd;

    rgb444_t rgb_q, rgb_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    frame_start_q, frame_start_d;

    vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .phase_o   (phase),
        .h_cnt_o   (h_cnt),
        .v_cnt_o   (v_cnt),
        .active_o  (active),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n)
    );

    assign bus_io.ram_addr_x = active ? scale_down(h_cnt) : '0;
    assign bus_io.ram_addr_y = active ? scale_down(v_cnt) : '0;

    assign pix         = pixel_t'(bus_io.ram_data);
    assign unused_rsvd = ^pix.rsvd;

    // Memory data is valid once READ_LAT clocks have passed since the address moved.
    assign capture = (phase == 2'(READ_LAT));

    always_comb begin
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (capture) begin
            hsync_d       = hsync_n;
            vsync_d       = vsync_n;
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (!active) begin
                rgb_d = '0;
            end else if (pix.transp) begin
                rgb_d = rgb444_t'(BG_COLOR);
            end else begin
                rgb_d = pix.rgb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus_io.vga_r       = rgb_q.r;
    assign bus_io.vga_g       = rgb_q.g;
    assign bus_io.vga_b       = rgb_q.b;
    assign bus_io.hsync       = hsync_q;
    assign bus_io.vsync       = vsync_q;
    assign bus_io.frame_start = frame_start_q;

endmodule
